expmod_scheduler: RTL and testbench

//  Shares one exponent_modulus engine between NUM_REQ requesters (UART host, key-store path, ...).

---
 rtl/expmod_pkg.sv | 23 ++
 rtl/expmod_scheduler_arbiter.sv | 33 +++
 rtl/expmod_scheduler.sv | 173 +++++++++++++++++
 tb/tb_expmod_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expmod_pkg.sv
// Shared types and defaults for the exponent-modulus job scheduler.
package expmod_pkg;

  localparam int MSG_WIDTH_DEF = 16;
  localparam int KEY_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MOD0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Requester ID width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/expmod_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter
  import expmod_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] idx_o
);

  logic found;
  int   cand;

  // Scan N positions starting at the pointer, wrapping modulo N.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/expmod_scheduler.sv
// Shares one exponent-modulus engine between NUM_REQ requesters.
//
// state | meaning
// IDLE  | waiting for a request while the engine is not busy; grant happens here
// START | one-cycle launch pulse to the engine, timeout counter cleared
// WAIT  | waiting for engine valid or timeout
// RESP  | response presented until the consumer accepts it
module expmod_scheduler
  import expmod_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MSG_WIDTH      = MSG_WIDTH_DEF,
  parameter int KEY_WIDTH      = KEY_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int IDW            = id_width(NUM_REQ)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]   req_value_in,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_exponent_in,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_modulus_in,
  output logic                           eng_start_out,
  output logic [MSG_WIDTH-1:0]           eng_value_out,
  output logic [KEY_WIDTH-1:0]           eng_exponent_out,
  output logic [KEY_WIDTH-1:0]           eng_modulus_out,
  input  logic                           eng_busy_in,
  input  logic                           eng_valid_in,
  input  logic [KEY_WIDTH-1:0]           eng_result_in,
  output logic                           rsp_valid_out,
  input  logic                           rsp_ready_in,
  output logic [IDW-1:0]                 rsp_id_out,
  output logic [KEY_WIDTH-1:0]           rsp_result_out,
  output logic [1:0]                     rsp_err_out,
  output logic                           busy_out
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

  sched_state_t         state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [MSG_WIDTH-1:0] value_q, value_d;
  logic [KEY_WIDTH-1:0] exp_q, exp_d;
  logic [KEY_WIDTH-1:0] mod_q, mod_d;
  logic [KEY_WIDTH-1:0] result_q, result_d;
  logic [1:0]           err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_idx;
  logic                 can_grant;
  logic [MSG_WIDTH-1:0] sel_value;
  logic [KEY_WIDTH-1:0] sel_exp;
  logic [KEY_WIDTH-1:0] sel_mod;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_arb (
    .req_i   (req_valid_in),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Operand mux for the granted requester and the grant qualifier.
  always_comb begin
    sel_value = req_value_in[int'(grant_idx)*MSG_WIDTH +: MSG_WIDTH];
    sel_exp   = req_exponent_in[int'(grant_idx)*KEY_WIDTH +: KEY_WIDTH];
    sel_mod   = req_modulus_in[int'(grant_idx)*KEY_WIDTH +: KEY_WIDTH];
    can_grant = (state_q == IDLE) && (|req_valid_in) && !eng_busy_in;
    // Reset gates the grant so no requester sees ready while reset is held.
    req_ready_out = (can_grant && rst_n_in) ? grant : '0;
  end

  // Next-state and register updates for the job sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    value_d  = value_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (can_grant) begin
          id_d    = grant_idx;
          value_d = sel_value;
          exp_d   = sel_exp;
          mod_d   = sel_mod;
          if (sel_mod == '0) begin
            result_d = '0;
            err_d    = ERR_MOD0;
            state_d  = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last counted cycle still wins over timeout.
        if (eng_valid_in) begin
          result_d = eng_result_in;
          err_d    = ERR_OK;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = ERR_TIMEOUT;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_in) begin
          ptr_d   = (id_q == ID_LAST) ? '0 : id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      value_q  <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      value_q  <= value_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from state and registered fields.
  always_comb begin
    eng_start_out    = (state_q == START);
    eng_value_out    = value_q;
    eng_exponent_out = exp_q;
    eng_modulus_out  = mod_q;
    rsp_valid_out    = (state_q == RESP);
    rsp_id_out       = id_q;
    rsp_result_out   = result_q;
    rsp_err_out      = err_q;
    busy_out         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_expmod_scheduler.sv
// Directed bench for expmod_scheduler with a behavioural engine model.
module tb_expmod_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_value;
  logic [63:0] req_exp;
  logic [63:0] req_mod;
  logic        eng_start;
  logic [15:0] eng_value;
  logic [31:0] eng_exponent;
  logic [31:0] eng_modulus;
  logic        eng_busy;
  logic        eng_valid;
  logic [31:0] eng_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;

  expmod_scheduler #(
    .NUM_REQ(2), .MSG_WIDTH(16), .KEY_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_value_in(req_value), .req_exponent_in(req_exp), .req_modulus_in(req_mod),
    .eng_start_out(eng_start), .eng_value_out(eng_value),
    .eng_exponent_out(eng_exponent), .eng_modulus_out(eng_modulus),
    .eng_busy_in(eng_busy), .eng_valid_in(eng_valid), .eng_result_in(eng_result),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready), .rsp_id_out(rsp_id),
    .rsp_result_out(rsp_result), .rsp_err_out(rsp_err), .busy_out(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  function automatic logic [31:0] modexp(input logic [15:0] v, input logic [31:0] e,
                                         input logic [31:0] m);
    longint unsigned r, b, mm;
    logic [31:0] ee;
    if (m == 0) return 32'd0;
    mm = longint'(m);
    r  = 1 % mm;
    b  = longint'(v) % mm;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % mm;
      b  = (b * b) % mm;
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [15:0] v, input logic [31:0] e,
                         input logic [31:0] m);
    req_value[i*16 +: 16] = v;
    req_exp[i*32 +: 32]   = e;
    req_mod[i*32 +: 32]   = m;
  endtask

  // Engine model: waits (bounded) for the launch pulse, then returns a result after lat cycles.
  task automatic serve(input int lat, output bit ok);
    int n;
    n = 0;
    while (!eng_start && n < 40) begin cyc(); n++; end
    ok = eng_start;
    cyc();
    repeat (lat) cyc();
    eng_result = modexp(eng_value, eng_exponent, eng_modulus);
    eng_valid  = 1'b1;
    cyc();
    eng_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    set_req(0, 16'd5, 32'd3, 32'd13);
    set_req(1, 16'd3, 32'd4, 32'd10);
    cyc(); cyc();
    n_cmp++;
    if ({req_ready, eng_start, eng_value, eng_exponent, eng_modulus, rsp_valid, rsp_id,
         rsp_result, rsp_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b start=%b busy=%b rsp_valid=%b expected all 0",
               req_ready, eng_start, busy, rsp_valid);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    int n0;
    set_req(0, 16'd5, 32'd3, 32'd13);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL single_grant: got %b expected 01", req_ready);
    end
    n0 = start_cnt;
    cyc();
    req_valid = 2'b00;
    n_cmp++;
    if ({eng_start, eng_value, eng_exponent, eng_modulus, busy} !== {1'b1, 16'd5, 32'd3, 32'd13, 1'b1}) begin
      n_bad++;
      $display("FAIL single_start: got start=%b v=%0d e=%0d m=%0d expected 1 5 3 13",
               eng_start, eng_value, eng_exponent, eng_modulus);
    end
    cyc();
    n_cmp++;
    if (eng_start !== 1'b0) begin
      n_bad++; $display("FAIL single_start_width: got %b expected 0 in WAIT", eng_start);
    end
    repeat (3) cyc();
    eng_result = modexp(eng_value, eng_exponent, eng_modulus);
    eng_valid  = 1'b1;
    cyc();
    eng_valid  = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b0, 2'b00, 32'd8}) begin
      n_bad++;
      $display("FAIL single_rsp: got v=%b id=%0d err=%0d res=%0d expected 1 0 0 8",
               rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    n_cmp++;
    if (start_cnt - n0 !== 1) begin
      n_bad++; $display("FAIL single_start_count: got %0d expected 1", start_cnt - n0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_accept: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] exp_res [2];
    int g;
    exp_res[0] = 32'd4;   // 2^5 mod 7
    exp_res[1] = 32'd1;   // 3^4 mod 10
    set_req(0, 16'd2, 32'd5, 32'd7);
    set_req(1, 16'd3, 32'd4, 32'd10);
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      g = (j % 2 == 0) ? 1 : 0;   // pointer is 1 after the previous job from requester 0
      #1;
      n_cmp++;
      if (req_ready !== (2'b01 << g)) begin
        n_bad++; $display("FAIL rr_grant_%0d: got %b expected %b", j, req_ready, 2'b01 << g);
      end
      serve(2, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rr_start_%0d: got no start expected start", j);
      end
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'(g), 2'b00, exp_res[g]}) begin
        n_bad++;
        $display("FAIL rr_rsp_%0d: got id=%0d err=%0d res=%0d expected id=%0d err=0 res=%0d",
                 j, rsp_id, rsp_err, rsp_result, g, exp_res[g]);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
    end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_mod_zero();
    int n0;
    set_req(1, 16'd9, 32'd2, 32'd0);
    req_valid = 2'b10;
    n0 = start_cnt;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL mod0_grant: got %b expected 10", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result, eng_start} !== {1'b1, 1'b1, 2'b01, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mod0_rsp: got v=%b id=%0d err=%0d res=%0d start=%b expected 1 1 1 0 0",
               rsp_valid, rsp_id, rsp_err, rsp_result, eng_start);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    n_cmp++;
    if (start_cnt - n0 !== 0) begin
      n_bad++; $display("FAIL mod0_no_start: got %0d starts expected 0", start_cnt - n0);
    end
  endtask

  task automatic test_timeout();
    int w;
    set_req(0, 16'd5, 32'd3, 32'd13);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL to_start: got %b expected 1", eng_start);
    end
    cyc();
    w = 0;
    while (busy && !rsp_valid && w < 40) begin w++; cyc(); end
    n_cmp++;
    if (w !== 16) begin
      n_bad++; $display("FAIL to_wait_cycles: got %0d expected 16", w);
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b0, 2'b10, 32'd0}) begin
      n_bad++;
      $display("FAIL to_rsp: got v=%b id=%0d err=%0d res=%0h expected 1 0 2 0",
               rsp_valid, rsp_id, rsp_err, rsp_result);
    end
    eng_result = 32'hDEAD_BEEF;
    eng_valid  = 1'b1;
    cyc();
    eng_valid  = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_result} !== {1'b1, 2'b10, 32'd0}) begin
      n_bad++; $display("FAIL to_late_valid: got err=%0d res=%0h expected 2 0", rsp_err, rsp_result);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    eng_valid = 1'b1;
    cyc();
    eng_valid = 1'b0;
    cyc();
    n_cmp++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL to_idle_valid: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_hold();
    bit ok;
    int bad;
    set_req(0, 16'd2, 32'd5, 32'd7);
    set_req(1, 16'd3, 32'd4, 32'd10);
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL hold_grant: got %b expected 10", req_ready);
    end
    serve(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL hold_start: got no start expected start");
    end
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if ({rsp_valid, rsp_id, rsp_err, rsp_result, req_ready} !== {1'b1, 1'b1, 2'b00, 32'd1, 2'b00})
        bad++;
      cyc();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    eng_busy = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, busy} !== 3'b000) begin
      n_bad++; $display("FAIL hold_eng_busy: got ready=%b busy=%b expected 00 0", req_ready, busy);
    end
    eng_busy = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL hold_next_grant: got %b expected 01", req_ready);
    end
    serve(1, ok);
    req_valid = 2'b00;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b0, 2'b00, 32'd4}) begin
      n_bad++;
      $display("FAIL hold_next_rsp: got id=%0d err=%0d res=%0d expected 0 0 4", rsp_id, rsp_err, rsp_result);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(1, 16'd3, 32'd4, 32'd10);
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00;
    cyc(); cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, eng_start, eng_value, eng_exponent, eng_modulus, rsp_valid, rsp_id,
         rsp_result, rsp_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got busy=%b v=%0d e=%0d m=%0d res=%0d expected all 0",
               busy, eng_value, eng_exponent, eng_modulus, rsp_result);
    end
    cyc();
    rst_n = 1'b1;
    set_req(0, 16'd5, 32'd3, 32'd13);
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL rstmid_grant: got %b expected 01", req_ready);
    end
    serve(2, ok);
    req_valid = 2'b00;
    n_cmp++;
    if ({ok, rsp_valid, rsp_id, rsp_err, rsp_result} !== {1'b1, 1'b1, 1'b0, 2'b00, 32'd8}) begin
      n_bad++;
      $display("FAIL rstmid_rsp: got start=%b id=%0d err=%0d res=%0d expected 1 0 0 8",
               ok, rsp_id, rsp_err, rsp_result);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_value  = '0;
    req_exp    = '0;
    req_mod    = '0;
    eng_busy   = 1'b0;
    eng_valid  = 1'b0;
    eng_result = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_mod_zero();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
